// File: rtl/reset_sequencer.sv
// reset_sequencer: staged reset release in the PLL output clock domain.
// The raw PLL lock is synchronized and filtered. Once lock is stable, the stage
// resets release one at a time, 2**STAGE_DLY_W cycles apart, stage 0 first.
// Lock loss re-asserts every stage at once and emits a one-cycle lock_lost pulse.
// A soft reset re-asserts every stage and holds them for SOFT_RST_HOLD cycles.
// Optional macro RESET_SEQUENCER_LOSS_COUNT_EN adds an 8-bit saturating
// lock-loss counter on port loss_count.
module reset_sequencer #(
    parameter int N_STAGES      = 3,
    parameter int STAGE_DLY_W   = 4,
    parameter int LOCK_FILT     = 4,
    parameter int SOFT_RST_HOLD = 16
) (
    input  logic                clk_256fs,
    input  logic                rst,
    input  logic                lock_in,
    input  logic                soft_rst_req,
    output logic [N_STAGES-1:0] rst_stage,
    output logic                ready,
`ifdef RESET_SEQUENCER_LOSS_COUNT_EN
    output logic [7:0]          loss_count,
`endif
    output logic                lock_lost
);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2,
        S_SOFT    = 2'd3
    } state_t;

    localparam logic [7:0] FILT_MAX = 8'(LOCK_FILT);
    localparam logic [7:0] HOLD_END = 8'(SOFT_RST_HOLD - 1);

    state_t                state_q, state_d;
    logic                  sync1_q, sync1_d;
    logic                  lock_s_q, lock_s_d;
    logic [7:0]            filt_q, filt_d;
    logic [STAGE_DLY_W-1:0] dly_q, dly_d;
    logic [7:0]            hold_q, hold_d;
    logic [N_STAGES-1:0]   rst_stage_q, rst_stage_d;
    logic                  ready_q, ready_d;
    logic                  lock_lost_q, lock_lost_d;
`ifdef RESET_SEQUENCER_LOSS_COUNT_EN
    logic [7:0]            loss_q, loss_d;
`endif

    // Next-state and output logic. Every output is registered so that
    // downstream resets never see combinational glitches.
    always_comb begin
        state_d     = state_q;
        sync1_d     = lock_in;
        lock_s_d    = sync1_q;
        dly_d       = dly_q;
        hold_d      = hold_q;
        rst_stage_d = rst_stage_q;
        ready_d     = ready_q;
        lock_lost_d = 1'b0;
        // The filter counts consecutive synchronized-high cycles and saturates.
        // Any low cycle clears it, which also handles the clear on lock loss.
        filt_d      = lock_s_q ? ((filt_q == FILT_MAX) ? filt_q : filt_q + 8'd1) : 8'd0;

        case (state_q)
            S_HOLD: begin
                rst_stage_d = '1;
                ready_d     = 1'b0;
                if (filt_d == FILT_MAX) begin
                    state_d = S_RELEASE;
                    dly_d   = '0;
                end
            end
            default: begin
                if (!lock_s_q) begin
                    // Lock loss takes priority over a coincident soft request.
                    state_d     = S_HOLD;
                    rst_stage_d = '1;
                    ready_d     = 1'b0;
                    lock_lost_d = 1'b1;
                    dly_d       = '0;
                end else if (soft_rst_req && state_q != S_SOFT) begin
                    state_d     = S_SOFT;
                    rst_stage_d = '1;
                    ready_d     = 1'b0;
                    hold_d      = 8'd0;
                end else begin
                    case (state_q)
                        S_RELEASE: begin
                            dly_d = dly_q + 1'b1;
                            if (&dly_q) begin
                                // Shifting a zero in from bit 0 releases stages in order.
                                rst_stage_d = rst_stage_q << 1;
                                if (rst_stage_d == '0) begin
                                    state_d = S_RUN;
                                    ready_d = 1'b1;
                                end
                            end
                        end
                        S_SOFT: begin
                            hold_d = hold_q + 8'd1;
                            if (hold_q == HOLD_END) begin
                                if (filt_q == FILT_MAX) begin
                                    state_d = S_RELEASE;
                                    dly_d   = '0;
                                end else begin
                                    state_d = S_HOLD;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

`ifdef RESET_SEQUENCER_LOSS_COUNT_EN
    // Lock-loss counter saturates at 255. Only rst clears it.
    always_comb begin
        loss_d = loss_q;
        if (lock_lost_d && loss_q != 8'hFF) loss_d = loss_q + 8'd1;
    end
`endif

    // State registers. rst returns everything to the held-in-reset condition.
    always_ff @(posedge clk_256fs or posedge rst) begin
        if (rst) begin
            state_q     <= S_HOLD;
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            filt_q      <= 8'd0;
            dly_q       <= '0;
            hold_q      <= 8'd0;
            rst_stage_q <= '1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
`ifdef RESET_SEQUENCER_LOSS_COUNT_EN
            loss_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            lock_s_q    <= lock_s_d;
            filt_q      <= filt_d;
            dly_q       <= dly_d;
            hold_q      <= hold_d;
            rst_stage_q <= rst_stage_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
`ifdef RESET_SEQUENCER_LOSS_COUNT_EN
            loss_q      <= loss_d;
`endif
        end
    end

    assign rst_stage = rst_stage_q;
    assign ready     = ready_q;
    assign lock_lost = lock_lost_q;
`ifdef RESET_SEQUENCER_LOSS_COUNT_EN
    assign loss_count = loss_q;
`endif

endmodule
